bp_be_store_buffer: RTL and testbench
=====================================

# bp_be_store_buffer

Parametrised committed-store buffer that sits between the memory pipe and the D$. It generalises the single-shot store path to `els_p` outstanding committed stores and drains them to the D$ in order through a valid/yumi port. It forwards store data to younger loads at dword granularity and flags partial overlaps for replay. Optional same-dword coalescing is selectable at compile time.

## Interface
- `els_p`, 4, number of entries; minimum 2, need not be a power of two
- `paddr_width_p`, 40, physical address width
- `dword_width_gp`, 64, data width; 8 byte lanes
- `clk_i`  in  1  clock; all state updates on posedge
- `reset_i`  in  1  reset; **asynchronous, active-high**
- `st_v_i`  in  1  committed store valid
- `st_paddr_i`  in  paddr_width_p  store byte address
- `st_size_i`  in  2  log2 of bytes (0=B, 1=H, 2=W, 3=D)
- `st_data_i`  in  64  store data, right-justified
- `st_ready_and_o`  out  1  buffer can accept a store this cycle
- `ld_v_i`  in  1  load probe valid
- `ld_paddr_i`  in  paddr_width_p  load byte address
- `ld_size_i`  in  2  load size
- `fwd_hit_o`  out  1  load fully covered by buffered data
- `fwd_data_o`  out  64  forwarded bytes, right-justified, zero-extended
- `fwd_conflict_o`  out  1  partial overlap; the load must replay
- `drain_v_o`  out  1  head entry valid
- `drain_paddr_o`  out  paddr_width_p  head dword address; low 3 bits zero
- `drain_mask_o`  out  8  head byte-lane mask
- `drain_data_o`  out  64  head data, lane-aligned
- `drain_yumi_i`  in  1  D$ consumes the head this cycle
- `fence_i`  in  1  level; block new stores until empty
- `empty_o`  out  1  no valid entries
- `count_o`  out  $clog2(els_p+1)  valid entry count

## Operation
- Circular FIFO with head/tail pointers. Pointers wrap from `els_p-1` to 0.
- Each entry holds: valid, dword address (`paddr[paddr_width_p-1:3]`), 8-bit mask, and 64-bit lane-aligned data.
- On enqueue: `mask = ((1<<(1<<size))-1) << paddr[2:0]` and `data = st_data_i << (8*paddr[2:0])`. Bits shifted past lane 7 are discarded. Misaligned stores never arrive here, because the MMU faults them upstream.
- `st_ready_and_o = (count_o != els_p) & ~fence_i`. An enqueue occurs when `st_v_i & st_ready_and_o`.
- Drain is valid-then-yumi: `drain_v_o = ~empty_o`, and `drain_yumi_i` pops the head in the same cycle. `drain_yumi_i` asserted while `drain_v_o` is 0 is illegal (assertion).
- Forwarding (combinational):
  - An entry overlaps the load if its dword address is equal and `(entry mask & load mask) != 0`.
  - Let Y be the youngest overlapping entry.
  - `fwd_hit_o = ld_v_i & (Y exists) & ((Y.mask & ldmask) == ldmask)`.
  - `fwd_data_o = (Y.data >> 8*ld_paddr[2:0])`, truncated to the load size and zero-extended.
  - `fwd_conflict_o = ld_v_i & (any overlap) & ~fwd_hit_o`.
  - If no entry overlaps, all three forwarding outputs are 0.
- An entry being drained in the current cycle still participates in forwarding during that cycle.
- Simultaneous enqueue and drain: count is unchanged and both pointers advance. When full, no enqueue is accepted even if a drain is occurring, because ready has no same-cycle bypass.
- Fence: while `fence_i` is high, the buffer accepts no new stores and drain proceeds normally. Fence completion is observed as `empty_o`.
- Reset (at any time, including mid-drain): all valid bits clear and pointers go to 0.
  - Reset values: `st_ready_and_o`=1 (if `fence_i`=0), `drain_v_o`=0, `empty_o`=1, `count_o`=0, `fwd_*`=0.
  - `drain_paddr_o`, `drain_mask_o` and `drain_data_o` are don't-care.

## Timing
- Enqueue latency: 1 cycle. A store accepted at edge N is visible to forwarding and drain from cycle N+1. There is no same-cycle store-to-load bypass.
- Drain: the head is presented combinationally from its register. After a pop the next entry is presented in the following cycle, giving one drain per cycle sustained.
- `count_o` and `empty_o` are registered-state derived and settle one cycle after an enqueue or pop.
- The forward path is purely combinational from registered entries plus `ld_*` inputs.

## Configuration
- `BP_BE_STORE_BUFFER_COALESCE_EN` **defined**:
  - An accepted store merges into the youngest entry instead of allocating when all hold: same dword, `count_o >= 2` (so the youngest is not the head), and the youngest is not being popped.
  - Merge updates: `mask |= new mask`; bytes under the new mask are overwritten.
  - A merge is accepted even when the buffer is full (`st_ready_and_o` is additionally high in that case, subject to `~fence_i`).
- **Undefined**: every accepted store allocates a new entry and the merge logic is absent.

## Test plan
- Fill and overflow: enqueue 4 SD with yumi held low (`els_p`=4) -> `count_o`=4, `st_ready_and_o`=0, and the fifth store is not accepted. Assert yumi for 1 cycle -> `count_o`=3 and ready=1.
- Forward hit: SW 0xDEADBEEF to 0x1004, then LW 0x1004 the next cycle -> `fwd_hit_o`=1, `fwd_data_o`=0xDEADBEEF. LB 0x1006 -> data 0xAD.
- Conflict: SB to 0x2000, then LD 0x2000 -> `fwd_hit_o`=0, `fwd_conflict_o`=1. LD 0x2008 -> both 0.
- Youngest wins: SD 0x11..11 then SD 0x22..22 to 0x3000 -> LD 0x3000 forwards 0x2222222222222222. Drain order: 0x11.. first.
- Wrap and simultaneous push/pop: 10 back-to-back stores with yumi asserted every cycle -> `count_o` stays ≤1 and drain order matches enqueue order across pointer wrap. Async reset pulsed mid-sequence -> `empty_o`=1 immediately and `drain_v_o`=0.
- Coalesce build: SD to 0x4000 then SB 0x55 to 0x4001 with 2+ entries queued -> `count_o` does not increase, and the drained entry has mask 0xFF with byte 1 = 0x55. Without the macro, `count_o` increments by 1.

Source files
------------

// File: rtl/bp_be_store_buffer.sv
// bp_be_store_buffer: committed-store FIFO between the memory pipe and the D$.
// Drains in order through a valid/yumi port and forwards dword-granular store
// data to younger loads, flagging partial overlaps for replay.
// Optional feature: define BP_BE_STORE_BUFFER_COALESCE_EN to merge a store into
// the youngest entry when it targets the same dword.
module bp_be_store_buffer #(
   parameter int els_p          = 4,
   parameter int paddr_width_p  = 40,
   parameter int dword_width_gp = 64,
   localparam int ptr_w_lp      = $clog2(els_p),
   localparam int cnt_w_lp      = $clog2(els_p + 1)
) (
   input  logic                      clk_i,
   input  logic                      reset_i,
   input  logic                      st_v_i,
   input  logic [paddr_width_p-1:0]  st_paddr_i,
   input  logic [1:0]                st_size_i,
   input  logic [dword_width_gp-1:0] st_data_i,
   output logic                      st_ready_and_o,
   input  logic                      ld_v_i,
   input  logic [paddr_width_p-1:0]  ld_paddr_i,
   input  logic [1:0]                ld_size_i,
   output logic                      fwd_hit_o,
   output logic [dword_width_gp-1:0] fwd_data_o,
   output logic                      fwd_conflict_o,
   output logic                      drain_v_o,
   output logic [paddr_width_p-1:0]  drain_paddr_o,
   output logic [7:0]                drain_mask_o,
   output logic [dword_width_gp-1:0] drain_data_o,
   input  logic                      drain_yumi_i,
   input  logic                      fence_i,
   output logic                      empty_o,
   output logic [cnt_w_lp-1:0]       count_o
);

   // Byte-lane mask of an access of 2^size bytes starting at lane 0.
   function automatic logic [7:0] size_mask(input logic [1:0] size);
      case (size)
         2'd0:    return 8'h01;
         2'd1:    return 8'h03;
         2'd2:    return 8'h0f;
         default: return 8'hff;
      endcase
   endfunction

   // Widen a byte-lane mask to a bit mask over the dword.
   function automatic logic [dword_width_gp-1:0] expand(input logic [7:0] m);
      logic [dword_width_gp-1:0] r;
      r = '0;
      for (int b = 0; b < 8; b++) r[8*b +: 8] = {8{m[b]}};
      return r;
   endfunction

   // Slot index of the entry that is i positions younger than the head.
   function automatic logic [ptr_w_lp-1:0] age_idx(input logic [ptr_w_lp-1:0] h, input int i);
      int s;
      s = int'(h) + i;
      if (s >= els_p) s = s - els_p;
      return ptr_w_lp'(s);
   endfunction

   function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
      return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + 1'b1;
   endfunction

   logic [els_p-1:0]          v_r;
   logic [paddr_width_p-4:0]  addr_r [els_p];
   logic [7:0]                mask_r [els_p];
   logic [dword_width_gp-1:0] data_r [els_p];
   logic [ptr_w_lp-1:0]       head_r, tail_r;
   logic [cnt_w_lp-1:0]       count_r;

   logic [paddr_width_p-4:0]  st_dw, ld_dw;
   logic [7:0]                st_mask, ld_mask;
   logic [dword_width_gp-1:0] st_data_sh;
   logic                      pop, merge, alloc;

   assign st_dw      = st_paddr_i[paddr_width_p-1:3];
   assign st_mask    = size_mask(st_size_i) << st_paddr_i[2:0];
   assign st_data_sh = st_data_i << {st_paddr_i[2:0], 3'b000};
   assign ld_dw      = ld_paddr_i[paddr_width_p-1:3];
   assign ld_mask    = size_mask(ld_size_i) << ld_paddr_i[2:0];

   assign count_o   = count_r;
   assign empty_o   = (count_r == '0);
   assign drain_v_o = ~empty_o;
   assign pop       = drain_yumi_i & drain_v_o;

`ifdef BP_BE_STORE_BUFFER_COALESCE_EN
   logic [ptr_w_lp-1:0] young_idx;
   logic                merge_ok;
   assign young_idx = (tail_r == '0) ? ptr_w_lp'(els_p - 1) : tail_r - 1'b1;
   // With two or more entries the youngest is never the head, so the pop term
   // is redundant but keeps the merge target safe from a same-cycle pop.
   assign merge_ok  = (count_r >= cnt_w_lp'(2)) & (addr_r[young_idx] == st_dw)
                    & ~(pop & (young_idx == head_r));
   assign st_ready_and_o = ((count_r != cnt_w_lp'(els_p)) | merge_ok) & ~fence_i;
   assign merge          = st_v_i & st_ready_and_o & merge_ok;
`else
   assign st_ready_and_o = (count_r != cnt_w_lp'(els_p)) & ~fence_i;
   assign merge          = 1'b0;
`endif
   assign alloc = st_v_i & st_ready_and_o & ~merge;

   // Occupancy state: valid bits, head/tail pointers and entry count.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         v_r     <= '0;
         head_r  <= '0;
         tail_r  <= '0;
         count_r <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         if (alloc) begin
            v_r[tail_r] <= 1'b1;
            tail_r      <= ptr_inc(tail_r);
         end
         if (pop) begin
            v_r[head_r] <= 1'b0;
            head_r      <= ptr_inc(head_r);
         end
         if (alloc & ~pop)      count_r <= count_r + 1'b1;
         else if (~alloc & pop) count_r <= count_r - 1'b1;
      end
   end

   // Entry payload write on allocate (and merge when coalescing is built in).
   // NOTE: payload storage has no reset; valid bits alone qualify its contents.
   always_ff @(posedge clk_i) begin
      if (alloc) begin
         addr_r[tail_r] <= st_dw;
         mask_r[tail_r] <= st_mask;
         data_r[tail_r] <= st_data_sh;
      end
`ifdef BP_BE_STORE_BUFFER_COALESCE_EN
      else if (merge) begin
         mask_r[young_idx] <= mask_r[young_idx] | st_mask;
         data_r[young_idx] <= (data_r[young_idx] & ~expand(st_mask))
                            | (st_data_sh & expand(st_mask));
      end
`endif
   end

   // Forwarding: scan oldest to youngest so the last overlap found is the youngest.
   logic                      y_found;
   logic [ptr_w_lp-1:0]       y_idx;
   logic [dword_width_gp-1:0] y_shift;
   always_comb begin
      // NOTE: defaults first so no path leaves a comb output unassigned (no latches).
      y_found = 1'b0;
      y_idx   = '0;
      for (int i = 0; i < els_p; i++) begin
         if (v_r[age_idx(head_r, i)] && (addr_r[age_idx(head_r, i)] == ld_dw)
             && ((mask_r[age_idx(head_r, i)] & ld_mask) != 8'h00)) begin
            y_found = 1'b1;
            y_idx   = age_idx(head_r, i);
         end
      end
      y_shift        = data_r[y_idx] >> {ld_paddr_i[2:0], 3'b000};
      fwd_hit_o      = ld_v_i & y_found & ((mask_r[y_idx] & ld_mask) == ld_mask);
      fwd_conflict_o = ld_v_i & y_found & ~fwd_hit_o;
      fwd_data_o     = (ld_v_i & y_found) ? (y_shift & expand(size_mask(ld_size_i))) : '0;
   end

   assign drain_paddr_o = {addr_r[head_r], 3'b000};
   assign drain_mask_o  = mask_r[head_r];
   assign drain_data_o  = data_r[head_r];

   drain_yumi_legal: assert property (@(posedge clk_i) disable iff (reset_i)
                                      drain_yumi_i |-> drain_v_o);

endmodule

// File: tb/tb_bp_be_store_buffer.sv
// Directed bench for bp_be_store_buffer (els_p = 4). Expectations follow the
// build: BP_BE_STORE_BUFFER_COALESCE_EN changes the merge results.
module tb_bp_be_store_buffer;

   localparam int els_p = 4;
   localparam int aw = 40;
`ifdef BP_BE_STORE_BUFFER_COALESCE_EN
   localparam bit coalesce_en = 1'b1;
`else
   localparam bit coalesce_en = 1'b0;
`endif

   logic          clk, reset_i;
   logic          st_v_i, st_ready_and_o;
   logic [aw-1:0] st_paddr_i;
   logic [1:0]    st_size_i;
   logic [63:0]   st_data_i;
   logic          ld_v_i;
   logic [aw-1:0] ld_paddr_i;
   logic [1:0]    ld_size_i;
   logic          fwd_hit_o, fwd_conflict_o;
   logic [63:0]   fwd_data_o;
   logic          drain_v_o, drain_yumi_i;
   logic [aw-1:0] drain_paddr_o;
   logic [7:0]    drain_mask_o;
   logic [63:0]   drain_data_o;
   logic          fence_i, empty_o;
   logic [2:0]    count_o;

   int n_cmp = 0;
   int n_bad = 0;

   bp_be_store_buffer #(.els_p(els_p), .paddr_width_p(aw), .dword_width_gp(64)) dut (
      .clk_i(clk), .reset_i(reset_i),
      .st_v_i(st_v_i), .st_paddr_i(st_paddr_i), .st_size_i(st_size_i),
      .st_data_i(st_data_i), .st_ready_and_o(st_ready_and_o),
      .ld_v_i(ld_v_i), .ld_paddr_i(ld_paddr_i), .ld_size_i(ld_size_i),
      .fwd_hit_o(fwd_hit_o), .fwd_data_o(fwd_data_o), .fwd_conflict_o(fwd_conflict_o),
      .drain_v_o(drain_v_o), .drain_paddr_o(drain_paddr_o), .drain_mask_o(drain_mask_o),
      .drain_data_o(drain_data_o), .drain_yumi_i(drain_yumi_i),
      .fence_i(fence_i), .empty_o(empty_o), .count_o(count_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic put_store(input logic [aw-1:0] a, input logic [1:0] sz, input logic [63:0] d);
      st_v_i = 1'b1; st_paddr_i = a; st_size_i = sz; st_data_i = d;
      tick();
      st_v_i = 1'b0;
   endtask

   task automatic pop_one();
      drain_yumi_i = 1'b1;
      tick();
      drain_yumi_i = 1'b0;
   endtask

   task automatic probe(input logic [aw-1:0] a, input logic [1:0] sz);
      ld_v_i = 1'b1; ld_paddr_i = a; ld_size_i = sz;
      @(negedge clk);
   endtask

   task automatic test_reset();
      probe(40'h0, 2'd3);
      n_cmp++; if (st_ready_and_o !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", st_ready_and_o); end
      n_cmp++; if (drain_v_o !== 1'b0) begin n_bad++; $display("FAIL reset_drain_v: got %b want 0", drain_v_o); end
      n_cmp++; if (empty_o !== 1'b1) begin n_bad++; $display("FAIL reset_empty: got %b want 1", empty_o); end
      n_cmp++; if (count_o !== 3'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", count_o); end
      n_cmp++; if ({fwd_hit_o, fwd_conflict_o} !== 2'b00 || fwd_data_o !== 64'h0) begin
         n_bad++; $display("FAIL reset_fwd: got hit=%b conf=%b data=%h want all 0", fwd_hit_o, fwd_conflict_o, fwd_data_o); end
      ld_v_i = 1'b0;
      tick();
   endtask

   task automatic test_fill();
      for (int k = 0; k < 4; k++) put_store(40'h100 + 40'(8*k), 2'd3, 64'hf0 + 64'(k));
      @(negedge clk);
      n_cmp++; if (count_o !== 3'd4) begin n_bad++; $display("FAIL fill_count: got %0d want 4", count_o); end
      n_cmp++; if (st_ready_and_o !== 1'b0) begin n_bad++; $display("FAIL fill_ready: got %b want 0", st_ready_and_o); end
      // Fifth store offered while full must be dropped.
      put_store(40'h200, 2'd3, 64'hbad);
      @(negedge clk);
      n_cmp++; if (count_o !== 3'd4) begin n_bad++; $display("FAIL overflow_count: got %0d want 4", count_o); end
      pop_one();
      @(negedge clk);
      n_cmp++; if (count_o !== 3'd3) begin n_bad++; $display("FAIL pop_count: got %0d want 3", count_o); end
      n_cmp++; if (st_ready_and_o !== 1'b1) begin n_bad++; $display("FAIL pop_ready: got %b want 1", st_ready_and_o); end
      for (int k = 1; k < 4; k++) begin
         n_cmp++; if (drain_data_o !== 64'hf0 + 64'(k) || drain_paddr_o !== 40'h100 + 40'(8*k)) begin
            n_bad++; $display("FAIL fill_order%0d: got %h@%h want %h@%h", k, drain_data_o, drain_paddr_o,
                              64'hf0 + 64'(k), 40'h100 + 40'(8*k)); end
         pop_one();
      end
      @(negedge clk);
      n_cmp++; if (empty_o !== 1'b1) begin n_bad++; $display("FAIL fill_empty: got %b want 1", empty_o); end
      tick();
   endtask

   task automatic test_forward();
      // Same-cycle store and load: no bypass.
      st_v_i = 1'b1; st_paddr_i = 40'h1004; st_size_i = 2'd2; st_data_i = 64'hdeadbeef;
      probe(40'h1004, 2'd2);
      n_cmp++; if ({fwd_hit_o, fwd_conflict_o} !== 2'b00) begin
         n_bad++; $display("FAIL no_bypass: got hit=%b conf=%b want 00", fwd_hit_o, fwd_conflict_o); end
      tick();
      st_v_i = 1'b0;
      @(negedge clk);
      n_cmp++; if (fwd_hit_o !== 1'b1 || fwd_data_o !== 64'hdeadbeef || fwd_conflict_o !== 1'b0) begin
         n_bad++; $display("FAIL fwd_lw: got hit=%b data=%h conf=%b want 1 deadbeef 0", fwd_hit_o, fwd_data_o, fwd_conflict_o); end
      probe(40'h1006, 2'd0);
      n_cmp++; if (fwd_hit_o !== 1'b1 || fwd_data_o !== 64'had) begin
         n_bad++; $display("FAIL fwd_lb: got hit=%b data=%h want 1 ad", fwd_hit_o, fwd_data_o); end
      probe(40'h1000, 2'd3);
      n_cmp++; if ({fwd_hit_o, fwd_conflict_o} !== 2'b01) begin
         n_bad++; $display("FAIL fwd_partial: got hit=%b conf=%b want 01", fwd_hit_o, fwd_conflict_o); end
      probe(40'h1002, 2'd1);
      n_cmp++; if ({fwd_hit_o, fwd_conflict_o} !== 2'b00 || fwd_data_o !== 64'h0) begin
         n_bad++; $display("FAIL fwd_disjoint: got hit=%b conf=%b data=%h want 0 0 0", fwd_hit_o, fwd_conflict_o, fwd_data_o); end
      ld_v_i = 1'b0;
      n_cmp++; if (drain_mask_o !== 8'hf0 || drain_paddr_o !== 40'h1000 || drain_data_o !== 64'hdeadbeef_00000000) begin
         n_bad++; $display("FAIL fwd_drain: got m=%h a=%h d=%h want f0 1000 deadbeef00000000", drain_mask_o, drain_paddr_o, drain_data_o); end
      pop_one();
   endtask

   task automatic test_conflict();
      put_store(40'h2000, 2'd0, 64'h7f);
      probe(40'h2000, 2'd3);
      n_cmp++; if ({fwd_hit_o, fwd_conflict_o} !== 2'b01) begin
         n_bad++; $display("FAIL conf_ld: got hit=%b conf=%b want 01", fwd_hit_o, fwd_conflict_o); end
      probe(40'h2008, 2'd3);
      n_cmp++; if ({fwd_hit_o, fwd_conflict_o} !== 2'b00) begin
         n_bad++; $display("FAIL conf_other_dword: got hit=%b conf=%b want 00", fwd_hit_o, fwd_conflict_o); end
      probe(40'h2000, 2'd0);
      n_cmp++; if (fwd_hit_o !== 1'b1 || fwd_data_o !== 64'h7f) begin
         n_bad++; $display("FAIL conf_lb: got hit=%b data=%h want 1 7f", fwd_hit_o, fwd_data_o); end
      ld_v_i = 1'b0;
      @(negedge clk);
      n_cmp++; if ({fwd_hit_o, fwd_conflict_o} !== 2'b00) begin
         n_bad++; $display("FAIL conf_ld_idle: got hit=%b conf=%b want 00", fwd_hit_o, fwd_conflict_o); end
      pop_one();
   endtask

   task automatic test_youngest();
      put_store(40'h3000, 2'd3, 64'h1111111111111111);
      put_store(40'h3000, 2'd3, 64'h2222222222222222);
      probe(40'h3000, 2'd3);
      n_cmp++; if (fwd_hit_o !== 1'b1 || fwd_data_o !== 64'h2222222222222222) begin
         n_bad++; $display("FAIL young_fwd: got hit=%b data=%h want 1 2222222222222222", fwd_hit_o, fwd_data_o); end
      n_cmp++; if (count_o !== 3'd2) begin n_bad++; $display("FAIL young_count: got %0d want 2", count_o); end
      ld_v_i = 1'b0;
      n_cmp++; if (drain_data_o !== 64'h1111111111111111) begin
         n_bad++; $display("FAIL young_drain0: got %h want 1111111111111111", drain_data_o); end
      pop_one();
      @(negedge clk);
      n_cmp++; if (drain_data_o !== 64'h2222222222222222) begin
         n_bad++; $display("FAIL young_drain1: got %h want 2222222222222222", drain_data_o); end
      pop_one();
   endtask

   task automatic test_fence();
      put_store(40'h8000, 2'd3, 64'h80);
      put_store(40'h8008, 2'd3, 64'h88);
      fence_i = 1'b1;
      @(negedge clk);
      n_cmp++; if (st_ready_and_o !== 1'b0) begin n_bad++; $display("FAIL fence_ready: got %b want 0", st_ready_and_o); end
      put_store(40'h9000, 2'd3, 64'h99);
      @(negedge clk);
      n_cmp++; if (count_o !== 3'd2) begin n_bad++; $display("FAIL fence_block: got %0d want 2", count_o); end
      pop_one();
      pop_one();
      @(negedge clk);
      n_cmp++; if (empty_o !== 1'b1) begin n_bad++; $display("FAIL fence_drain: got %b want 1", empty_o); end
      fence_i = 1'b0;
      @(negedge clk);
      n_cmp++; if (st_ready_and_o !== 1'b1) begin n_bad++; $display("FAIL fence_release: got %b want 1", st_ready_and_o); end
      tick();
   endtask

   task automatic test_back_to_back();
      st_v_i = 1'b1; st_size_i = 2'd3; st_paddr_i = 40'h5000; st_data_i = 64'h5a00;
      tick();
      for (int k = 1; k < 10; k++) begin
         st_paddr_i = 40'h5000 + 40'(8*k); st_data_i = 64'h5a00 + 64'(k);
         drain_yumi_i = 1'b1;
         @(negedge clk);
         n_cmp++; if (count_o !== 3'd1 || drain_data_o !== 64'h5a00 + 64'(k-1)) begin
            n_bad++; $display("FAIL b2b_%0d: got cnt=%0d data=%h want 1 %h", k, count_o, drain_data_o, 64'h5a00 + 64'(k-1)); end
         tick();
      end
      st_v_i = 1'b0;
      @(negedge clk);
      n_cmp++; if (drain_data_o !== 64'h5a09) begin n_bad++; $display("FAIL b2b_last: got %h want 5a09", drain_data_o); end
      tick();
      drain_yumi_i = 1'b0;
      @(negedge clk);
      n_cmp++; if (empty_o !== 1'b1) begin n_bad++; $display("FAIL b2b_empty: got %b want 1", empty_o); end
      tick();
      // Async reset mid-cycle with entries queued.
      put_store(40'h5100, 2'd3, 64'h1);
      put_store(40'h5108, 2'd3, 64'h2);
      #2 reset_i = 1'b1;
      #1;
      n_cmp++; if (empty_o !== 1'b1 || drain_v_o !== 1'b0 || count_o !== 3'd0) begin
         n_bad++; $display("FAIL async_reset: got empty=%b v=%b cnt=%0d want 1 0 0", empty_o, drain_v_o, count_o); end
      tick();
      reset_i = 1'b0;
      put_store(40'h5200, 2'd3, 64'h77);
      @(negedge clk);
      n_cmp++; if (count_o !== 3'd1 || drain_data_o !== 64'h77) begin
         n_bad++; $display("FAIL post_reset: got cnt=%0d data=%h want 1 77", count_o, drain_data_o); end
      pop_one();
   endtask

   task automatic test_coalesce();
      logic [63:0] want_data;
      logic [2:0]  want_cnt;
      want_cnt  = coalesce_en ? 3'd2 : 3'd3;
      want_data = coalesce_en ? 64'h0102030405065508 : 64'h0102030405060708;
      put_store(40'h6000, 2'd3, 64'h66);
      put_store(40'h4000, 2'd3, 64'h0102030405060708);
      put_store(40'h4001, 2'd0, 64'h55);
      @(negedge clk);
      n_cmp++; if (count_o !== want_cnt) begin n_bad++; $display("FAIL coal_count: got %0d want %0d", count_o, want_cnt); end
      pop_one();
      @(negedge clk);
      n_cmp++; if (drain_paddr_o !== 40'h4000 || drain_mask_o !== 8'hff || drain_data_o !== want_data) begin
         n_bad++; $display("FAIL coal_entry: got a=%h m=%h d=%h want 4000 ff %h", drain_paddr_o, drain_mask_o, drain_data_o, want_data); end
      pop_one();
      @(negedge clk);
      n_cmp++; if (empty_o !== coalesce_en) begin n_bad++; $display("FAIL coal_remaining: got empty=%b want %b", empty_o, coalesce_en); end
      while (drain_v_o) pop_one();
      // Full buffer: a same-dword store is mergeable only in the coalescing build.
      for (int k = 0; k < 3; k++) put_store(40'h100 + 40'(8*k), 2'd3, 64'(k));
      put_store(40'h7000, 2'd3, 64'h70);
      st_paddr_i = 40'h7000;
      @(negedge clk);
      n_cmp++; if (st_ready_and_o !== coalesce_en) begin
         n_bad++; $display("FAIL full_merge_ready: got %b want %b", st_ready_and_o, coalesce_en); end
      st_paddr_i = 40'h7008;
      #1;
      n_cmp++; if (st_ready_and_o !== 1'b0) begin n_bad++; $display("FAIL full_nomerge_ready: got %b want 0", st_ready_and_o); end
      for (int k = 0; k < 4; k++) pop_one();
      @(negedge clk);
      n_cmp++; if (empty_o !== 1'b1) begin n_bad++; $display("FAIL coal_final_empty: got %b want 1", empty_o); end
   endtask

   initial begin
      reset_i = 1'b1; st_v_i = 1'b0; st_paddr_i = '0; st_size_i = '0; st_data_i = '0;
      ld_v_i = 1'b0; ld_paddr_i = '0; ld_size_i = '0; drain_yumi_i = 1'b0; fence_i = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset_i = 1'b0;
      test_reset();
      test_fill();
      test_forward();
      test_conflict();
      test_youngest();
      test_fence();
      test_back_to_back();
      test_coalesce();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
